// File: rtl/axis_frame_sink.sv
// AXI-Stream video frame sink: checks line/frame geometry carried on tuser,
// accumulates a per-frame checksum and reports sticky protocol errors.
module axis_frame_sink #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 4
) (
    input  logic                  aclk,
    input  logic                  aclk_reset_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  cfg_enable,
    input  logic [15:0]           cfg_exp_words,
    input  logic [15:0]           cfg_exp_lines,
    input  logic [15:0]           cfg_ready_pattern,
    input  logic                  err_clr,
    output logic                  frame_done,
    output logic [31:0]           frame_count,
    output logic [15:0]           last_line_count,
    output logic [31:0]           last_checksum,
    output logic [4:0]            err_flags,
    output logic                  irq_err
);

    typedef enum logic [1:0] {IDLE, IN_LINE, GAP} state_t;

    localparam int ERR_SOF  = 0;
    localparam int ERR_SOL  = 1;
    localparam int ERR_GW   = 2;
    localparam int ERR_GL   = 3;
    localparam int ERR_LAST = 4;

    state_t      state_q, state_d;
    logic        run_q;
    logic [3:0]  idx_q;
    logic [15:0] pattern_eff;
    logic [15:0] word_q, word_d, line_q, line_d;
    logic [31:0] cks_q, cks_d;
    logic        done_q, done_d;
    logic [31:0] fc_q, fc_d;
    logic [15:0] llc_q, llc_d;
    logic [31:0] lcs_q, lcs_d;
    logic [4:0]  err_q, err_new;

    logic        beat, sof, eof, sol, eol;
    logic [63:0] beat_data;
    logic [31:0] fold;

    logic        restart, line_beat;
    logic [15:0] word_b, line_b, word_inc, line_inc;
    logic [31:0] cks_b, cks_inc;

    assign sof       = s_axis_tuser[0];
    assign eof       = s_axis_tuser[1];
    assign sol       = s_axis_tuser[2];
    assign eol       = s_axis_tuser[3];
    assign beat_data = 64'(s_axis_tdata);
    assign fold      = beat_data[63:32] ^ beat_data[31:0];

    // An all-zero pattern would stall the stream forever, so it means "always ready".
    assign pattern_eff   = (cfg_ready_pattern == 16'h0000) ? 16'hFFFF : cfg_ready_pattern;
    assign s_axis_tready = run_q & cfg_enable & pattern_eff[idx_q];
    assign beat          = s_axis_tvalid & s_axis_tready;

    // run_q holds tready low while reset is asserted and releases it on the first edge after.
    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            run_q <= 1'b0;
            idx_q <= '0;
        end else begin
            run_q <= 1'b1;
            idx_q <= idx_q + 4'd1;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d   = state_q;
        word_d    = word_q;
        line_d    = line_q;
        cks_d     = cks_q;
        done_d    = 1'b0;
        fc_d      = fc_q;
        llc_d     = llc_q;
        lcs_d     = lcs_q;
        err_new   = '0;
        restart   = 1'b0;
        line_beat = 1'b0;

        if (beat) begin
            if (s_axis_tlast != eol) err_new[ERR_LAST] = 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (sof) restart = 1'b1;
                    else     err_new[ERR_SOF] = 1'b1;
                end
                IN_LINE: begin
                    if (sof) begin
                        restart          = 1'b1;
                        err_new[ERR_SOF] = 1'b1;
                    end else begin
                        line_beat = 1'b1;
                    end
                end
                GAP: begin
                    if (sof) begin
                        restart          = 1'b1;
                        err_new[ERR_SOF] = 1'b1;
                    end else begin
                        line_beat = 1'b1;
                        if (!sol) err_new[ERR_SOL] = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A restarting SOF beat is the first beat of a fresh frame, so it counts from zero.
        word_b   = restart ? 16'd0 : word_q;
        line_b   = restart ? 16'd0 : line_q;
        cks_b    = restart ? 32'd0 : cks_q;
        word_inc = (word_b == 16'hFFFF) ? word_b : word_b + 16'd1;
        line_inc = line_b + 16'd1;
        cks_inc  = cks_b ^ fold;

        if (restart || line_beat) begin
            cks_d = cks_inc;
            if (eol || eof) begin
                if (!eol || word_inc != cfg_exp_words) err_new[ERR_GW] = 1'b1;
                word_d = '0;
                line_d = line_inc;
                if (eof) begin
                    if (line_inc != cfg_exp_lines) err_new[ERR_GL] = 1'b1;
                    llc_d   = line_inc;
                    lcs_d   = cks_inc;
                    fc_d    = fc_q + 32'd1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end else begin
                word_d  = word_inc;
                line_d  = line_b;
                state_d = IN_LINE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            line_q  <= '0;
            cks_q   <= '0;
            done_q  <= 1'b0;
            fc_q    <= '0;
            llc_q   <= '0;
            lcs_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            line_q  <= line_d;
            cks_q   <= cks_d;
            done_q  <= done_d;
            fc_q    <= fc_d;
            llc_q   <= llc_d;
            lcs_q   <= lcs_d;
            // A freshly detected error survives a simultaneous clear.
            err_q   <= (err_clr ? 5'b0 : err_q) | err_new;
        end
    end

    assign frame_done      = done_q;
    assign frame_count     = fc_q;
    assign last_line_count = llc_q;
    assign last_checksum   = lcs_q;
    assign err_flags       = err_q;
    assign irq_err         = |err_q;

endmodule
